// File: rtl/bdense_seq.sv
// Sequential binarized dense layer: latches one input vector, then evaluates one
// XNOR-popcount-threshold neuron per clock and offers the result vector downstream.
module bdense_seq #(
   parameter int IWIDTH = 16,
   parameter int OWIDTH = 8,
   parameter int CW = $clog2(IWIDTH + 1),
   parameter logic [OWIDTH*IWIDTH-1:0] WEIGHTS = '0,
   parameter logic [OWIDTH*CW-1:0] THRESHS = {OWIDTH{CW'(IWIDTH / 2)}}
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IWIDTH-1:0] vecX,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OWIDTH-1:0] vecO,
   output logic              busy
);
   localparam int NW = (OWIDTH > 1) ? $clog2(OWIDTH) : 1;
   localparam logic [NW-1:0] LAST = NW'(OWIDTH - 1);

   typedef enum logic [1:0] {IDLE, COMPUTE, DONE} stateT;

   stateT             state;
   stateT             stateNext;
   logic [IWIDTH-1:0] xReg;
   logic [NW-1:0]     neuronIdx;
   logic [OWIDTH-1:0] result;
   logic [IWIDTH-1:0] curRow;
   logic [CW-1:0]     curThr;
   logic [IWIDTH-1:0] agree;
   logic [CW-1:0]     popCnt;
   logic              neuronBit;

   // NOTE: flops take non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= stateNext;
   end

   // NOTE: the default up front covers every path, so no latch can be inferred.
   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (in_valid) stateNext = COMPUTE;
         COMPUTE: if (neuronIdx == LAST) stateNext = DONE;
         DONE:    if (out_ready) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Pick the weight row and threshold of the neuron being evaluated this cycle.
   always_comb begin
      curRow = '0;
      curThr = '0;
      for (int i = 0; i < OWIDTH; i++) begin
         if (neuronIdx == NW'(i)) begin
            curRow = WEIGHTS[i*IWIDTH +: IWIDTH];
            curThr = THRESHS[i*CW +: CW];
         end
      end
   end

   always_comb begin
      agree  = ~(xReg ^ curRow);
      popCnt = '0;
      for (int b = 0; b < IWIDTH; b++) popCnt = popCnt + CW'(agree[b]);
      neuronBit = (popCnt >= curThr);
   end

   // NOTE: the data registers are reset as well, so an aborted vector leaves vecO at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xReg      <= '0;
         neuronIdx <= '0;
         result    <= '0;
      end else if (state == IDLE && in_valid) begin
         xReg      <= vecX;
         neuronIdx <= '0;
         result    <= '0;
      end else if (state == COMPUTE) begin
         for (int i = 0; i < OWIDTH; i++) begin
            if (neuronIdx == NW'(i)) result[i] <= neuronBit;
         end
         if (neuronIdx != LAST) neuronIdx <= neuronIdx + 1'b1;
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state == COMPUTE);
   assign vecO      = result;
endmodule

// File: tb/tb_bdense_seq.sv
// Self-checking bench for bdense_seq: four configurations, scoreboard queues fed at
// input acceptance and drained at output handshakes, plus directed timing checks.
module tb_bdense_seq;
   localparam logic [7:0]   WA = 8'b1100_1010;
   localparam logic [5:0]   TA = 6'b010_010;
   localparam logic [127:0] WB = '0;
   localparam logic [39:0]  TB = {8{5'd8}};
   localparam logic [127:0] WC = 128'h3C5A_F00F_1234_ABCD_8001_7FFE_0F0F_9669;
   localparam logic [39:0]  TC = {5'd7, 5'd9, 5'd8, 5'd1, 5'd17, 5'd16, 5'd31, 5'd0};
   localparam logic [3:0]   WD = 4'b0110;
   localparam logic [2:0]   TD = 3'd3;

   logic clk;
   logic rst_n;
   logic aInValid, aInReady, aOutValid, aOutReady, aBusy;
   logic [3:0] aVecX;
   logic [1:0] aVecO;
   logic bcInValid, bcOutReady, bInReady, bOutValid, bBusy, cInReady, cOutValid, cBusy;
   logic [15:0] bcVecX;
   logic [7:0] bVecO, cVecO;
   logic dInValid, dInReady, dOutValid, dOutReady, dBusy;
   logic [3:0] dVecX;
   logic dVecO;

   logic [1:0] aQ[$];
   logic [7:0] bQ[$];
   logic [7:0] cQ[$];
   logic       dQ[$];

   int errors = 0;
   int checks = 0;
   int aOuts = 0;

   bdense_seq #(.IWIDTH(4), .OWIDTH(2), .CW(3), .WEIGHTS(WA), .THRESHS(TA)) dutA (
      .clk(clk), .rst_n(rst_n), .in_valid(aInValid), .in_ready(aInReady), .vecX(aVecX),
      .out_valid(aOutValid), .out_ready(aOutReady), .vecO(aVecO), .busy(aBusy));
   bdense_seq dutB (
      .clk(clk), .rst_n(rst_n), .in_valid(bcInValid), .in_ready(bInReady), .vecX(bcVecX),
      .out_valid(bOutValid), .out_ready(bcOutReady), .vecO(bVecO), .busy(bBusy));
   bdense_seq #(.WEIGHTS(WC), .THRESHS(TC)) dutC (
      .clk(clk), .rst_n(rst_n), .in_valid(bcInValid), .in_ready(cInReady), .vecX(bcVecX),
      .out_valid(cOutValid), .out_ready(bcOutReady), .vecO(cVecO), .busy(cBusy));
   bdense_seq #(.IWIDTH(4), .OWIDTH(1), .CW(3), .WEIGHTS(WD), .THRESHS(TD)) dutD (
      .clk(clk), .rst_n(rst_n), .in_valid(dInValid), .in_ready(dInReady), .vecX(dVecX),
      .out_valid(dOutValid), .out_ready(dOutReady), .vecO(dVecO), .busy(dBusy));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: count agreeing bit positions, compare against the threshold field.
   function automatic logic [7:0] refDense(input logic [15:0] x, input int iw, input int ow,
                                           input int cw, input logic [127:0] w, input logic [39:0] t);
      logic [7:0] r;
      int agreeCnt;
      int thr;
      r = '0;
      for (int i = 0; i < ow; i++) begin
         agreeCnt = 0;
         thr = 0;
         for (int j = 0; j < iw; j++) if (x[j] == w[i*iw + j]) agreeCnt++;
         for (int k = 0; k < cw; k++) if (t[i*cw + k]) thr += (1 << k);
         r[i] = (agreeCnt >= thr);
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst_n && aInValid && aInReady)
         aQ.push_back(2'(refDense(16'(aVecX), 4, 2, 3, 128'(WA), 40'(TA))));
      if (rst_n && bcInValid && bInReady) bQ.push_back(refDense(bcVecX, 16, 8, 5, WB, TB));
      if (rst_n && bcInValid && cInReady) cQ.push_back(refDense(bcVecX, 16, 8, 5, WC, TC));
      if (rst_n && dInValid && dInReady)
         dQ.push_back(1'(refDense(16'(dVecX), 4, 1, 3, 128'(WD), 40'(TD))));
      if (aOutValid && aOutReady) begin
         aOuts++;
         if (aQ.size() == 0) check("A_unexpected_out", 16'(aOutValid), 16'd0);
         else check("A_vecO", 16'(aVecO), 16'(aQ.pop_front()));
      end
      if (bOutValid && bcOutReady) begin
         if (bQ.size() == 0) check("B_unexpected_out", 16'(bOutValid), 16'd0);
         else check("B_vecO", 16'(bVecO), 16'(bQ.pop_front()));
      end
      if (cOutValid && bcOutReady) begin
         if (cQ.size() == 0) check("C_unexpected_out", 16'(cOutValid), 16'd0);
         else check("C_vecO", 16'(cVecO), 16'(cQ.pop_front()));
      end
      if (dOutValid && dOutReady) begin
         if (dQ.size() == 0) check("D_unexpected_out", 16'(dOutValid), 16'd0);
         else check("D_vecO", 16'(dVecO), 16'(dQ.pop_front()));
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation did not finish");
   end

   initial begin
      int lat;
      int outsBefore;
      logic [15:0] vecs [13];
      logic [3:0] dVecs [3];
      vecs = '{16'h0000, 16'hFFFF, 16'h00FF, 16'h1234, 16'hABCD, 16'h5A5A, 16'hF00F,
               16'h8001, 16'h7FFE, 16'h3C3C, 16'h9669, 16'hC35A, 16'h0F0F};
      dVecs = '{4'b0110, 4'b1001, 4'b0111};

      rst_n = 1'b0;
      aInValid = 1'b0; aOutReady = 1'b0; aVecX = '0;
      bcInValid = 1'b0; bcOutReady = 1'b0; bcVecX = '0;
      dInValid = 1'b0; dOutReady = 1'b0; dVecX = '0;
      repeat (2) step();
      check("rst_inReady", 16'(aInReady), 16'd1);
      check("rst_outValid", 16'(aOutValid), 16'd0);
      check("rst_busy", 16'(aBusy), 16'd0);
      check("rst_vecO", 16'(aVecO), 16'd0);
      check("rst_B_vecO", 16'(bVecO), 16'd0);
      rst_n = 1'b1;

      // Single vector, one-cycle valid pulse, downstream always ready
      step();
      aVecX = 4'b1010; aInValid = 1'b1; aOutReady = 1'b1;
      @(negedge clk); check("t1_inReady", 16'(aInReady), 16'd1);
      step(); aInValid = 1'b0;
      @(negedge clk); check("t1_busyT0", 16'(aBusy), 16'd1); check("t1_ovT0", 16'(aOutValid), 16'd0);
      @(negedge clk); check("t1_ovT1", 16'(aOutValid), 16'd0);
      @(negedge clk); check("t1_ovT2", 16'(aOutValid), 16'd1); check("t1_irT2", 16'(aInReady), 16'd0);
      @(negedge clk); check("t1_ovT3", 16'(aOutValid), 16'd0); check("t1_irT3", 16'(aInReady), 16'd1);

      // Back-to-back vectors with in_valid held
      step();
      aVecX = 4'b0101; aInValid = 1'b1;
      step(); aVecX = 4'b0011;
      @(negedge clk); check("t2_irS0", 16'(aInReady), 16'd0);
      @(negedge clk);
      @(negedge clk); check("t2_ovS2", 16'(aOutValid), 16'd1);
      @(negedge clk); check("t2_irS3", 16'(aInReady), 16'd1);
      step(); aInValid = 1'b0;
      @(negedge clk); check("t2_busyS4", 16'(aBusy), 16'd1);
      lat = 0;
      while (!aOutValid && lat < 20) begin @(negedge clk); lat++; end
      check("t2_lat", 16'(lat), 16'd2);

      // Output backpressure; changing vecX during the hold is ignored
      step();
      aVecX = 4'b1010; aInValid = 1'b1; aOutReady = 1'b0;
      step(); aVecX = 4'b0101;
      @(negedge clk);
      lat = 0;
      while (!aOutValid && lat < 20) begin @(negedge clk); lat++; end
      check("t3_lat", 16'(lat), 16'd2);
      for (int k = 0; k < 5; k++) begin
         step(); aVecX = 4'(k * 3 + 1);
         @(negedge clk);
         check("t3_holdOv", 16'(aOutValid), 16'd1);
         check("t3_holdVecO", 16'(aVecO), 16'b11);
         check("t3_holdIr", 16'(aInReady), 16'd0);
      end
      step(); aInValid = 1'b0; aOutReady = 1'b1;
      @(negedge clk); check("t3_relOv", 16'(aOutValid), 16'd1);
      @(negedge clk);
      check("t3_idleOv", 16'(aOutValid), 16'd0);
      check("t3_idleIr", 16'(aInReady), 16'd1);
      check("t3_vecOKept", 16'(aVecO), 16'b11);

      // Reset one cycle into COMPUTE discards the vector
      step();
      aVecX = 4'b1010; aInValid = 1'b1;
      step(); aInValid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      aQ.delete(); bQ.delete(); cQ.delete(); dQ.delete();
      #1;
      check("t4_rstOv", 16'(aOutValid), 16'd0);
      check("t4_rstBusy", 16'(aBusy), 16'd0);
      check("t4_rstVecO", 16'(aVecO), 16'd0);
      check("t4_rstIr", 16'(aInReady), 16'd1);
      outsBefore = aOuts;
      step(); rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); check("t4_noOut", 16'(aOutValid), 16'd0);
      end
      check("t4_outCount", 16'(aOuts), 16'(outsBefore));
      step();
      aVecX = 4'b0011; aInValid = 1'b1;
      step(); aInValid = 1'b0;
      @(negedge clk);
      lat = 0;
      while (!aOutValid && lat < 20) begin @(negedge clk); lat++; end
      check("t4_lat", 16'(lat), 16'd2);

      // Single-neuron layer: COMPUTE lasts one cycle
      dOutReady = 1'b1;
      for (int v = 0; v < 3; v++) begin
         step();
         dVecX = dVecs[v]; dInValid = 1'b1;
         step(); dInValid = 1'b0;
         @(negedge clk); check("D_busy", 16'(dBusy), 16'd1);
         lat = 0;
         while (!dOutValid && lat < 20) begin @(negedge clk); lat++; end
         check("D_lat", 16'(lat), 16'd1);
      end

      // Default layer (B) and boundary-threshold layer (C) in lockstep
      bcOutReady = 1'b1;
      for (int v = 0; v < 13; v++) begin
         step();
         bcVecX = vecs[v]; bcInValid = 1'b1;
         step(); bcInValid = 1'b0;
         @(negedge clk);
         lat = 0;
         while (!bOutValid && lat < 40) begin @(negedge clk); lat++; end
         check("BC_lat", 16'(lat), 16'd8);
         check("C_sync", 16'(cOutValid), 16'd1);
      end
      step();
      @(negedge clk);

      check("A_drained", 16'(aQ.size()), 16'd0);
      check("B_drained", 16'(bQ.size()), 16'd0);
      check("C_drained", 16'(cQ.size()), 16'd0);
      check("D_drained", 16'(dQ.size()), 16'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
